weight_stream: RTL

WEIGHT_STREAM -- requirements
Module: weight_stream

---
 rtl/weight_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/weight_stream.sv
// Row-streaming weight buffer: a DEPTH x (LANES*DATA_W) register file read out as a
// valid/ready beat stream. Define WS_STALL_CNT_EN to add the stall_cnt output.
module weight_stream #(
  parameter  int DATA_W = 32,
  parameter  int LANES  = 128,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ROW_W  = LANES * DATA_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              abort,
  input  logic              out_ready,
`ifdef WS_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   ONE_ROW  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  logic [ROW_W-1:0]  mem [DEPTH];
  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rows_left;

  logic start_take;
  logic load_en;
  logic finish;
  logic kill;

  // Row addresses wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ROW) ? '0 : a + 1'b1;
  endfunction

  // NOTE: storage is deliberately left out of reset so rows survive a reset and a
  // large array stays a plain register file without a reset fan-out.
  always_ff @(posedge clka) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clka) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    start_take = 1'b0;
    load_en    = 1'b0;
    finish     = 1'b0;
    kill       = 1'b0;
    case (state)
      IDLE: begin
        // abort outranks start, even though abort alone does nothing in IDLE
        if (start && !abort) begin
          start_take = 1'b1;
          if (num_rows != '0) state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          kill       = 1'b1;
          state_next = IDLE;
        end else if (out_valid && out_ready && out_last) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if ((!out_valid || out_ready) && rows_left != '0) begin
          load_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // The read is combinational from the pre-edge array, so a same-cycle write to
  // the row being loaded reaches the output one stream later, not this beat.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rd_addr   <= '0;
      rows_left <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_take) begin
        if (num_rows != '0) begin
          out_valid <= 1'b1;
          out_data  <= mem[base_addr];
          out_last  <= (num_rows == ONE_ROW);
          rd_addr   <= wrap_inc(base_addr);
          rows_left <= num_rows - ONE_ROW;
        end else begin
          done <= 1'b1;
        end
      end else if (kill) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        rows_left <= '0;
      end else if (finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end else if (load_en) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_addr];
        out_last  <= (rows_left == ONE_ROW);
        rd_addr   <= wrap_inc(rd_addr);
        rows_left <= rows_left - ONE_ROW;
      end
    end
  end

`ifdef WS_STALL_CNT_EN
  always_ff @(posedge clka) begin
    if (!rst_n || start_take) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
